// File: rtl/masked_random_source.sv
// masked_random_source: bank of seeded xorshift32 lanes feeding the in_random port of the masked S-box.
// Latency: 1 cycle from a consumed word to the next; NUM_LANES + WARMUP_CYCLES cycles from first seed beat to first word.
// Backpressure: in_ready=0 holds every lane, so out_random stays stable; seeding is refused only during warm-up.
//
// Ports:
//   in_clock / in_reset          rising-edge clock, asynchronous active-high reset
//   in_seed / in_seed_valid      seed beat for the lane being loaded, accepted with out_seed_ready
//   out_random / out_valid       random word (lane k in bits [32k+31:32k], truncated), valid in RUN
//   in_ready                     consumer takes out_random this cycle
module masked_random_source #(
  parameter int OUT_WIDTH     = 64,
  parameter int WARMUP_CYCLES = 4
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic [31:0]          in_seed,
  input  logic                 in_seed_valid,
  output logic                 out_seed_ready,
  output logic [OUT_WIDTH-1:0] out_random,
  output logic                 out_valid,
  input  logic                 in_ready
);

  localparam int NUM_LANES = (OUT_WIDTH + 31) / 32;
  localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W     = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_WARM,
    ST_RUN
  } state_e;

  state_e                    state_q, state_d;
  logic [NUM_LANES*32-1:0]   lanes_q, lanes_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic                      seed_rdy;
  logic                      seed_fire;
  logic [31:0]               seed_word;
  logic [IDX_W-1:0]          beat_idx;

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  assign seed_rdy  = (state_q != ST_WARM);
  assign seed_fire = in_seed_valid && seed_rdy;
  // Zero is the xorshift fixed point; a lane seeded with it would emit zeros forever.
  assign seed_word = (in_seed == 32'h0) ? 32'h0000_0001 : in_seed;
  // A beat arriving outside SEED always starts a fresh seeding pass at lane 0.
  assign beat_idx  = (state_q == ST_SEED) ? idx_q : '0;

  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    if (seed_fire) begin
      // Seed has priority over a consume in RUN: only the addressed lane changes.
      for (int k = 0; k < NUM_LANES; k++) begin
        if (beat_idx == IDX_W'(k)) begin
          lanes_d[32*k +: 32] = seed_word;
        end
      end
      if (beat_idx == LAST_IDX) begin
        idx_d = '0;
        cnt_d = '0;
        if (WARMUP_CYCLES > 0) begin
          state_d = ST_WARM;
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        idx_d   = beat_idx + IDX_W'(1);
        state_d = ST_SEED;
      end
    end else begin
      case (state_q)
        ST_WARM: begin
          for (int k = 0; k < NUM_LANES; k++) begin
            lanes_d[32*k +: 32] = xs_step(lanes_q[32*k +: 32]);
          end
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (in_ready) begin
            for (int k = 0; k < NUM_LANES; k++) begin
              lanes_d[32*k +: 32] = xs_step(lanes_q[32*k +: 32]);
            end
          end
        end
        default: begin
          // IDLE and SEED: lanes hold until a beat arrives.
        end
      endcase
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q <= ST_IDLE;
      lanes_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs depend on state only; reset masks them while it is held.
  assign out_seed_ready = !in_reset && seed_rdy;
  assign out_valid      = !in_reset && (state_q == ST_RUN);
  assign out_random     = lanes_q[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_masked_random_source.sv
module tb_masked_random_source;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: 64-bit, no warm-up. B: 64-bit, 4 warm-up steps. C: 36-bit, 4 warm-up steps.
  logic [31:0] seed_a, seed_b, seed_c;
  logic        sv_a, sv_b, sv_c;
  logic        sr_a, sr_b, sr_c;
  logic [63:0] rnd_a, rnd_b;
  logic [35:0] rnd_c;
  logic        vld_a, vld_b, vld_c;
  logic        rdy_a, rdy_b, rdy_c;

  int checks   = 0;
  int failures = 0;

  masked_random_source #(.OUT_WIDTH(64), .WARMUP_CYCLES(0)) u_a (
    .in_clock(clk), .in_reset(rst), .in_seed(seed_a), .in_seed_valid(sv_a),
    .out_seed_ready(sr_a), .out_random(rnd_a), .out_valid(vld_a), .in_ready(rdy_a));

  masked_random_source #(.OUT_WIDTH(64), .WARMUP_CYCLES(4)) u_b (
    .in_clock(clk), .in_reset(rst), .in_seed(seed_b), .in_seed_valid(sv_b),
    .out_seed_ready(sr_b), .out_random(rnd_b), .out_valid(vld_b), .in_ready(rdy_b));

  masked_random_source #(.OUT_WIDTH(36), .WARMUP_CYCLES(4)) u_c (
    .in_clock(clk), .in_reset(rst), .in_seed(seed_c), .in_seed_valid(sv_c),
    .out_seed_ready(sr_c), .out_random(rnd_c), .out_valid(vld_c), .in_ready(rdy_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference xorshift32 step.
  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] xs4(input logic [31:0] x);
    return xs(xs(xs(xs(x))));
  endfunction

  function automatic logic [31:0] nz(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  logic [63:0] held;
  logic [31:0] w, m0, m1, s0, s1;
  logic        r;

  initial begin
    seed_a = '0; seed_b = '0; seed_c = '0;
    sv_a = 0; sv_b = 0; sv_c = 0;
    rdy_a = 0; rdy_b = 0; rdy_c = 0;

    // ---- reset state ----
    #2;
    chk("rst_vld", {63'b0, vld_a}, 64'd0);
    chk("rst_sr", {63'b0, sr_a}, 64'd0);
    chk("rst_rnd", rnd_a, 64'd0);
    repeat (2) @(negedge clk);
    rst = 0;

    // ---- idle with no seed ----
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_vld", {63'b0, vld_a}, 64'd0);
    end
    chk("idle_sr", {63'b0, sr_a}, 64'd1);
    chk("idle_rnd", rnd_a, 64'd0);

    // ---- A: seeds 1 then 0, no warm-up ----
    sv_a = 1; seed_a = 32'h1;
    @(negedge clk);
    chk("a_seed_mid_vld", {63'b0, vld_a}, 64'd0);
    seed_a = 32'h0;
    @(negedge clk);
    sv_a = 0;
    chk("a_first_vld", {63'b0, vld_a}, 64'd1);
    chk("a_first_rnd", rnd_a, 64'h00000001_00000001);
    rdy_a = 1;
    @(negedge clk);
    rdy_a = 0;
    chk("a_step1", rnd_a, 64'h00042021_00042021);

    // stall: 10 cycles with in_ready low
    held = rnd_a;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("a_stall", rnd_a, 64'h00042021_00042021);
    end
    // then 3 consumed words
    w = 32'h00042021;
    rdy_a = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      w = xs(w);
      chk("a_run", rnd_a, {w, w});
      chk("a_distinct", {63'b0, (rnd_a != held)}, 64'd1);
      held = rnd_a;
    end
    rdy_a = 0;
    chk("a_step2_const", {32'h0, xs(32'h00042021)}, 64'h00000000_04080601);

    // ---- asynchronous reset mid-cycle ----
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("arst_vld", {63'b0, vld_a}, 64'd0);
    chk("arst_sr", {63'b0, sr_a}, 64'd0);
    chk("arst_rnd", rnd_a, 64'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("arst_idle_vld", {63'b0, vld_a}, 64'd0);

    // ---- B: warm-up of 4, seeds 1,1 ----
    sv_b = 1; seed_b = 32'h1;
    @(negedge clk);
    @(negedge clk);
    sv_b = 0;
    for (int i = 0; i < 4; i++) begin
      chk("b_warm_sr", {63'b0, sr_b}, 64'd0);
      chk("b_warm_vld", {63'b0, vld_b}, 64'd0);
      @(negedge clk);
    end
    chk("b_run_sr", {63'b0, sr_b}, 64'd1);
    chk("b_run_vld", {63'b0, vld_b}, 64'd1);
    chk("b_first", rnd_b, {xs4(32'h1), xs4(32'h1)});

    // ---- B: reseed in RUN with in_ready high the same cycle ----
    rdy_b = 1; sv_b = 1; seed_b = 32'hDEADBEEF;
    @(negedge clk);
    rdy_b = 0;
    chk("b_reseed_vld", {63'b0, vld_b}, 64'd0);
    chk("b_reseed_lanes", rnd_b, {xs4(32'h1), 32'hDEADBEEF});
    seed_b = 32'h12345678;
    @(negedge clk);
    sv_b = 0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("b_resume_vld", {63'b0, vld_b}, 64'd1);
    chk("b_resume_rnd", rnd_b, {xs4(32'h12345678), xs4(32'hDEADBEEF)});

    // ---- C: 36-bit, random seeds, random in_ready ----
    s0 = $urandom; s1 = $urandom;
    sv_c = 1; seed_c = s0;
    @(negedge clk);
    seed_c = s1;
    @(negedge clk);
    sv_c = 0;
    m0 = xs4(nz(s0));
    m1 = xs4(nz(s1));
    for (int i = 0; i < 20 && !vld_c; i++) @(negedge clk);
    chk("c_vld_up", {63'b0, vld_c}, 64'd1);
    for (int i = 0; i < 1000; i++) begin
      chk("c_word", {28'b0, rnd_c}, {28'b0, m1[3:0], m0});
      r = 1'($urandom_range(0, 1));
      rdy_c = r;
      @(negedge clk);
      if (r) begin
        m0 = xs(m0);
        m1 = xs(m1);
      end
    end
    rdy_c = 0;
    chk("c_vld_end", {63'b0, vld_c}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/masked_random_source.md
Name: masked_random_source

Overview:
- Producer end of the `in_random` interface of the masked GF(2^8) inverse pipeline and its helper gadgets (`masked_hpc1_mul`, `masked_hpc3_1_mul`, `masked_zero`).
- A bank of seeded xorshift32 lanes supplies a fresh OUT_WIDTH-bit random word every accepted cycle.
- A seeding handshake loads the lanes, and a warm-up phase runs before any word is released.
- Sits beside the S-box datapath; its output is sliced by the consumer exactly as the consumer's port defines.

Parameters:
- OUT_WIDTH, 64, width of `out_random`; instantiated with `num_4stage_inv_random(NUM_SHARES)`. Must be ≥1.
- WARMUP_CYCLES, 4, number of free-running lane steps after seeding before output is valid; 0 allowed.
- NUM_LANES, derived localparam = ceil(OUT_WIDTH/32).

Ports:
- in_clock  input  1  clock, rising edge.
- in_reset  input  1  reset; one clock; reset is asynchronous and active-high.
- in_seed  input  32  seed word for the lane currently being loaded.
- in_seed_valid  input  1  seed beat present.
- out_seed_ready  output  1  seed beat accepted when `in_seed_valid` & `out_seed_ready`.
- out_random  output  OUT_WIDTH  random word; lane k state occupies bits [32k+31:32k]; truncated to OUT_WIDTH.
- out_valid  output  1  `out_random` is fresh and may be consumed.
- in_ready  input  1  consumer takes `out_random` this cycle.

Behaviour:
- Lane step (xorshift32): x ^= x<<13; x ^= x>>17; x ^= x<<5, all 32-bit with truncation.
- FSM states:
  - IDLE: lanes unseeded.
  - SEED: loading lanes 0..NUM_LANES-1 in order.
  - WARM: stepping lanes during warm-up.
  - RUN: output valid.
- Reset (asynchronous assert, synchronous-clean deassert):
  - state = IDLE, all lane states = 0, lane index = 0, warm counter = 0.
  - `out_valid` = 0, `out_seed_ready` = 0 during reset; `out_random` = 0.
- `out_seed_ready`:
  - 1 in IDLE, SEED and RUN; 0 in WARM.
  - Combinational from state only, never from `in_seed_valid`.
- Seed beat accepted (IDLE/SEED/RUN):
  - Lane[index] <= `in_seed`; a zero seed word is replaced by 32'h00000001 (xorshift fixed point forbidden).
  - index increments.
  - From IDLE or RUN, the beat always targets lane 0 and the state becomes SEED. A beat in RUN is a reseed: `out_valid` drops the next cycle and no further words are released until reseeding completes.
  - Final beat (index = NUM_LANES-1):
    - index returns to 0.
    - Next state WARM with counter = 0 if WARMUP_CYCLES > 0; otherwise RUN directly.
    - NUM_LANES = 1 means the first beat is also the final beat.
- WARM:
  - All lanes step every cycle, counter increments.
  - After WARMUP_CYCLES steps, state = RUN.
  - `out_valid` first asserts in the cycle after the last warm step.
- RUN:
  - `out_valid` = 1.
  - If `in_ready` = 1 and no seed beat is accepted, all lanes step at the clock edge, so a new word appears the next cycle.
  - If `in_ready` = 0, lanes hold and `out_random` is stable.
  - Seed beat and `in_ready` in the same RUN cycle: the seed takes priority. The word shown that cycle counts as consumed, lane 0 loads the seed, other lanes hold.
- Lanes never step in IDLE or SEED.
- `out_random` is driven directly from lane registers (no combinational path from inputs).
- Reset asserted mid-operation (any state, including a partial seed): immediate return to reset values; a new full seed is required.
- Latency: 1 cycle from a consumed word to the next word; NUM_LANES + WARMUP_CYCLES cycles from the first seed beat to the first valid word with back-to-back beats.

Test Plan:
- Reset then idle with no seed: `out_valid` = 0 for 100 cycles, `out_seed_ready` = 1, `out_random` = 0; reassert `in_reset` mid-cycle → outputs clear without waiting for a clock edge.
- OUT_WIDTH=64, WARMUP_CYCLES=0, seed beats 32'h1 then 32'h0:
  - Next cycle `out_valid` = 1, `out_random` = 64'h00000001_00000001 (zero substituted).
  - Pulse `in_ready` → next `out_random` = 64'h00042021_00042021.
- Stall: as above, hold `in_ready` = 0 for 10 cycles → `out_random` constant; then `in_ready` = 1 for 3 cycles → exactly 3 distinct successive words, each matching the reference model.
- WARMUP_CYCLES=4, seeds 1,1:
  - `out_seed_ready` = 0 for exactly 4 cycles after the final beat.
  - First valid word = step⁴(1) in each lane, per the C xorshift32 model.
- Reseed in RUN with `in_ready` = 1 the same cycle:
  - `out_valid` = 0 the next cycle, lane 0 = new seed, lane 1 unchanged.
  - After the second beat, output resumes with the new lane values.
- OUT_WIDTH=36 (NUM_LANES=2), random seeds, 1000 cycles of random `in_ready` against the model: every consumed word matches, upper 28 bits of lane 1 are never exposed, no step occurs without a handshake.
